// File: rtl/multi_cycle_ctrl.sv
// Main control FSM for the multi-cycle MIPS datapath.
// Sequences fetch/decode/execute/memory/writeback per opcode, drives the datapath
// mux selects, register/memory enables and the 2-bit ALUOp consumed by ALUCtrl.
// Memory requests stall on mem_ready.
// Optional feature: define MULTI_CYCLE_CTRL_PERF_EN to add cycle_cnt/instr_cnt counters.
module multi_cycle_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       alu_zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_en,
  output logic [1:0] pc_source,
  output logic [1:0] alu_op,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       halted
`ifdef MULTI_CYCLE_CTRL_PERF_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instr_cnt
`endif
);

  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_SUB = 2'b01;
  localparam logic [1:0] ALUOP_RTY = 2'b10;
  localparam logic [1:0] ALUOP_AND = 2'b11;

  localparam logic [5:0] OpRType = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpAndi  = 6'b001100;
  localparam logic [5:0] OpJ     = 6'b000010;

  typedef enum logic [3:0] {
    StIdle, StFetch, StDecode, StMemAddr, StMemRead, StMemWb, StMemWrite,
    StRExec, StRWb, StBranch, StImmExec, StImmWb, StJump, StHalt
  } state_e;

  state_e state_q, state_d;

  // Opcode sub-variant bits captured in DECODE; opcode is not trusted afterwards.
  logic is_bne_q, is_sw_q, is_andi_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Latch opcode variant bits while decoding (bit 0: bne, bit 3: sw, bit 2: andi).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_bne_q  <= 1'b0;
      is_sw_q   <= 1'b0;
      is_andi_q <= 1'b0;
    end else if (state_q == StDecode) begin
      is_bne_q  <= opcode[0];
      is_sw_q   <= opcode[3];
      is_andi_q <= opcode[2];
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   state_d = StFetch;
      StFetch:  if (mem_ready) state_d = StDecode;
      StDecode: begin
        unique case (opcode)
          OpRType:       state_d = StRExec;
          OpLw, OpSw:    state_d = StMemAddr;
          OpBeq, OpBne:  state_d = StBranch;
          OpAddi, OpAndi: state_d = StImmExec;
          OpJ:           state_d = StJump;
          default:       state_d = StHalt;
        endcase
      end
      StMemAddr:  state_d = is_sw_q ? StMemWrite : StMemRead;
      StMemRead:  if (mem_ready) state_d = StMemWb;
      StMemWb:    state_d = StFetch;
      StMemWrite: if (mem_ready) state_d = StFetch;
      StRExec:    state_d = StRWb;
      StRWb:      state_d = StFetch;
      StBranch:   state_d = StFetch;
      StImmExec:  state_d = StImmWb;
      StImmWb:    state_d = StFetch;
      StJump:     state_d = StFetch;
      StHalt:     state_d = StHalt;
      default:    state_d = StIdle;
    endcase
  end

  // Output decode; only FETCH and BRANCH look at inputs.
  always_comb begin
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_en      = 1'b0;
    pc_source  = 2'b00;
    alu_op     = ALUOP_ADD;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    halted     = 1'b0;
    unique case (state_q)
      StFetch: begin
        mem_req   = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_en     = mem_ready;
      end
      StDecode: alu_src_b = 2'b11;
      StMemAddr: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      StMemRead: begin
        mem_req = 1'b1;
        iord    = 1'b1;
      end
      StMemWb: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      StMemWrite: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      StRExec: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_RTY;
      end
      StRWb: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      StBranch: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_SUB;
        pc_source = 2'b01;
        pc_en     = alu_zero ^ is_bne_q;
      end
      StImmExec: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = is_andi_q ? ALUOP_AND : ALUOP_ADD;
      end
      StImmWb: reg_write = 1'b1;
      StJump: begin
        pc_source = 2'b10;
        pc_en     = 1'b1;
      end
      StHalt:  halted = 1'b1;
      default: ;
    endcase
  end

`ifdef MULTI_CYCLE_CTRL_PERF_EN
  // Performance counters: active cycles and retired instructions (re-entries into FETCH).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt <= 32'd0;
      instr_cnt <= 32'd0;
    end else begin
      if (state_q != StIdle && state_q != StHalt) cycle_cnt <= cycle_cnt + 32'd1;
      if (state_d == StFetch && state_q != StIdle && state_q != StFetch) begin
        instr_cnt <= instr_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Scoreboard bench for multi_cycle_ctrl: the driver pushes hand-computed output vectors,
// a monitor pops and compares on each falling edge.
module tb_multi_cycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       alu_zero, mem_ready;
  logic       mem_req, mem_write, iord, ir_write, pc_en;
  logic [1:0] pc_source, alu_op, alu_src_b;
  logic       alu_src_a, reg_write, reg_dst, mem_to_reg, halted;
`ifdef MULTI_CYCLE_CTRL_PERF_EN
  logic [31:0] cycle_cnt, instr_cnt;
`endif

  always #5 clk = ~clk;

  multi_cycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .alu_zero(alu_zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_write(mem_write), .iord(iord), .ir_write(ir_write),
    .pc_en(pc_en), .pc_source(pc_source), .alu_op(alu_op), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .halted(halted)
`ifdef MULTI_CYCLE_CTRL_PERF_EN
    , .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
`endif
  );

  // {mem_req,mem_write,iord,ir_write,pc_en,pc_source,alu_op,alu_src_a,alu_src_b,
  //  reg_write,reg_dst,mem_to_reg,halted}
  logic [15:0] outv;
  assign outv = {mem_req, mem_write, iord, ir_write, pc_en, pc_source, alu_op, alu_src_a,
                 alu_src_b, reg_write, reg_dst, mem_to_reg, halted};

  localparam logic [15:0] E_IDLE   = 16'b0_0_0_0_0_00_00_0_00_0_0_0_0;
  localparam logic [15:0] E_FETCH  = 16'b1_0_0_1_1_00_00_0_01_0_0_0_0;
  localparam logic [15:0] E_FWAIT  = 16'b1_0_0_0_0_00_00_0_01_0_0_0_0;
  localparam logic [15:0] E_DEC    = 16'b0_0_0_0_0_00_00_0_11_0_0_0_0;
  localparam logic [15:0] E_MADDR  = 16'b0_0_0_0_0_00_00_1_10_0_0_0_0;
  localparam logic [15:0] E_MREAD  = 16'b1_0_1_0_0_00_00_0_00_0_0_0_0;
  localparam logic [15:0] E_MWB    = 16'b0_0_0_0_0_00_00_0_00_1_0_1_0;
  localparam logic [15:0] E_MWRITE = 16'b1_1_1_0_0_00_00_0_00_0_0_0_0;
  localparam logic [15:0] E_REXEC  = 16'b0_0_0_0_0_00_10_1_00_0_0_0_0;
  localparam logic [15:0] E_RWB    = 16'b0_0_0_0_0_00_00_0_00_1_1_0_0;
  localparam logic [15:0] E_BR_T   = 16'b0_0_0_0_1_01_01_1_00_0_0_0_0;
  localparam logic [15:0] E_BR_N   = 16'b0_0_0_0_0_01_01_1_00_0_0_0_0;
  localparam logic [15:0] E_ADDI   = 16'b0_0_0_0_0_00_00_1_10_0_0_0_0;
  localparam logic [15:0] E_ANDI   = 16'b0_0_0_0_0_00_11_1_10_0_0_0_0;
  localparam logic [15:0] E_IMMWB  = 16'b0_0_0_0_0_00_00_0_00_1_0_0_0;
  localparam logic [15:0] E_JUMP   = 16'b0_0_0_0_1_10_00_0_00_0_0_0_0;
  localparam logic [15:0] E_HALT   = 16'b0_0_0_0_0_00_00_0_00_0_0_0_1;

  typedef struct {
    string       nm;
    logic [15:0] v;
    bit          perf;
    logic [31:0] cyc;
    logic [31:0] ins;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  bit          perf_next = 1'b0;
  logic [31:0] perf_cyc = 32'd0;
  logic [31:0] perf_ins = 32'd0;

  // Monitor: one scoreboard entry per falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (outv !== e.v) begin
          failures++;
          $display("FAIL %s: outputs got %b expected %b", e.nm, outv, e.v);
        end
`ifdef MULTI_CYCLE_CTRL_PERF_EN
        if (e.perf) begin
          checks++;
          if (cycle_cnt !== e.cyc) begin
            failures++;
            $display("FAIL %s_cycle_cnt: got %0d expected %0d", e.nm, cycle_cnt, e.cyc);
          end
          checks++;
          if (instr_cnt !== e.ins) begin
            failures++;
            $display("FAIL %s_instr_cnt: got %0d expected %0d", e.nm, instr_cnt, e.ins);
          end
        end
`endif
      end
    end
  end

  // Drive one cycle's inputs (at posedge+1) and queue the expected outputs for that cycle.
  task automatic step(input string nm, input logic [5:0] op, input logic mr, input logic az,
                      input logic [15:0] ev);
    exp_t e;
    opcode    = op;
    mem_ready = mr;
    alu_zero  = az;
    e.nm   = nm;
    e.v    = ev;
    e.perf = perf_next;
    e.cyc  = perf_cyc;
    e.ins  = perf_ins;
    perf_next = 1'b0;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic run_j();
    step("j_fetch", 6'b000010, 1'b1, 1'b0, E_FETCH);
    step("j_decode", 6'b000010, 1'b1, 1'b0, E_DEC);
    step("j_jump", 6'b000010, 1'b1, 1'b0, E_JUMP);
  endtask

  task automatic run_branch(input string nm, input logic [5:0] op, input logic az,
                            input logic [15:0] ev);
    step({nm, "_fetch"}, op, 1'b1, az, E_FETCH);
    step({nm, "_decode"}, op, 1'b1, az, E_DEC);
    step({nm, "_branch"}, op, 1'b1, az, ev);
  endtask

  task automatic run_imm(input string nm, input logic [5:0] op, input logic [15:0] ev);
    step({nm, "_fetch"}, op, 1'b1, 1'b0, E_FETCH);
    step({nm, "_decode"}, op, 1'b1, 1'b0, E_DEC);
    step({nm, "_exec"}, op, 1'b1, 1'b0, ev);
    step({nm, "_wb"}, op, 1'b1, 1'b0, E_IMMWB);
  endtask

  initial begin
    int budget;
    rst_n     = 1'b0;
    opcode    = 6'd0;
    mem_ready = 1'b0;
    alu_zero  = 1'b0;
    @(posedge clk);
    #1;
    step("reset_idle", 6'd0, 1'b1, 1'b0, E_IDLE);
    rst_n = 1'b1;
    step("release_idle", 6'd0, 1'b1, 1'b0, E_IDLE);

    // Three back-to-back jumps; counters checked in the following FETCH.
    run_j();
    run_j();
    run_j();
    perf_next = 1'b1;
    perf_cyc  = 32'd9;
    perf_ins  = 32'd3;

    // R-type; mem_ready low in DECODE must not stall.
    step("r_fetch", 6'b000000, 1'b1, 1'b0, E_FETCH);
    step("r_decode", 6'b000000, 1'b0, 1'b0, E_DEC);
    step("r_exec", 6'b000000, 1'b1, 1'b0, E_REXEC);
    step("r_wb", 6'b000000, 1'b1, 1'b0, E_RWB);

    // lw with one fetch wait and two MEM_READ waits.
    step("lw_fetch_wait", 6'b100011, 1'b0, 1'b0, E_FWAIT);
    step("lw_fetch", 6'b100011, 1'b1, 1'b0, E_FETCH);
    step("lw_decode", 6'b100011, 1'b1, 1'b0, E_DEC);
    step("lw_addr", 6'b100011, 1'b1, 1'b0, E_MADDR);
    step("lw_read_w0", 6'b100011, 1'b0, 1'b0, E_MREAD);
    step("lw_read_w1", 6'b100011, 1'b0, 1'b0, E_MREAD);
    step("lw_read", 6'b100011, 1'b1, 1'b0, E_MREAD);
    step("lw_wb", 6'b100011, 1'b1, 1'b0, E_MWB);

    // sw with one wait; opcode changes after DECODE must be ignored.
    step("sw_fetch", 6'b101011, 1'b1, 1'b0, E_FETCH);
    step("sw_decode", 6'b101011, 1'b1, 1'b0, E_DEC);
    step("sw_addr", 6'b100011, 1'b1, 1'b0, E_MADDR);
    step("sw_write_w0", 6'b100011, 1'b0, 1'b0, E_MWRITE);
    step("sw_write", 6'b100011, 1'b1, 1'b0, E_MWRITE);

    run_branch("beq_z1", 6'b000100, 1'b1, E_BR_T);
    run_branch("bne_z1", 6'b000101, 1'b1, E_BR_N);
    run_branch("beq_z0", 6'b000100, 1'b0, E_BR_N);
    run_branch("bne_z0", 6'b000101, 1'b0, E_BR_T);

    run_imm("addi", 6'b001000, E_ADDI);
    run_imm("andi", 6'b001100, E_ANDI);

    // Reset while in MEM_READ: outputs clear before any clock edge.
    step("rst_lw_fetch", 6'b100011, 1'b1, 1'b0, E_FETCH);
    step("rst_lw_decode", 6'b100011, 1'b1, 1'b0, E_DEC);
    step("rst_lw_addr", 6'b100011, 1'b1, 1'b0, E_MADDR);
    step("rst_lw_read", 6'b100011, 1'b0, 1'b0, E_MREAD);
    rst_n = 1'b0;
    step("async_reset", 6'b100011, 1'b1, 1'b0, E_IDLE);
    step("reset_hold", 6'b100011, 1'b1, 1'b0, E_IDLE);
    rst_n = 1'b1;
    step("release_idle2", 6'b100011, 1'b1, 1'b0, E_IDLE);
    step("fetch_after_reset", 6'b000010, 1'b1, 1'b0, E_FETCH);
    step("j2_decode", 6'b000010, 1'b1, 1'b0, E_DEC);
    step("j2_jump", 6'b000010, 1'b1, 1'b0, E_JUMP);

    // Illegal opcode traps and stays halted.
    step("ill_fetch", 6'b111111, 1'b1, 1'b0, E_FETCH);
    step("ill_decode", 6'b111111, 1'b1, 1'b0, E_DEC);
    for (int i = 0; i < 100; i++) begin
      step("halt_sticky", 6'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           E_HALT);
    end

    budget = 0;
    while (sb.size() > 0 && budget < 10) begin
      @(posedge clk);
      budget++;
    end
    if (sb.size() > 0) begin
      failures++;
      $display("FAIL drain: %0d entries left, required 0", sb.size());
    end
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
